// File: rtl/isr_controller.sv
// isr_controller: arbitrates level interrupts, saves the resume PC and issues fetch redirects on entry and uret.
module isr_controller #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] ISR_BASE   = 32'h0000_1000,
  parameter logic [31:0] VEC_STRIDE = 32'h10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               gie,
  input  logic               pipe_stall,
  input  logic               branch_flush,
  input  logic               jump_flush,
  input  logic               id_valid,
  input  logic [31:0]        id_pc,
  input  logic               id_uret,
  output logic               ISR_PC_flush,
  output logic               ISR_pipe_flush,
  output logic [31:0]        isr_pc_new,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               isr_running,
  output logic [31:0]        sav_pc
);
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  typedef enum logic [1:0] {IDLE, ENTER, RUN, EXIT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] irq_id, win;
  logic [NUM_IRQ-1:0] pending;
  logic ok, take;
  always_comb begin
    pending = irq_in & irq_en & {NUM_IRQ{gie}};
    ok = id_valid & ~pipe_stall & ~branch_flush & ~jump_flush;
    take = |pending & ok;
    win = '0;
    // descending scan so the lowest pending index is the last write
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pending[i]) win = IW'(i);
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? ENTER : IDLE;
      ENTER:   state_nx = RUN;
      RUN:     state_nx = (id_uret & ok) ? EXIT : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sav_pc <= '0;
      irq_id <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && take) begin
        sav_pc <= id_pc;
        irq_id <= win;
      end
    end
  end
  assign ISR_PC_flush   = state == ENTER || state == EXIT;
  assign ISR_pipe_flush = ISR_PC_flush;
  assign isr_running    = state != IDLE;
  assign isr_pc_new     = state == ENTER ? ISR_BASE + 32'(irq_id) * VEC_STRIDE :
                          state == EXIT  ? sav_pc : '0;
  assign irq_ack        = state == ENTER ? NUM_IRQ'(1) << irq_id : '0;
endmodule

// File: tb/tb_isr_controller.sv
// tb_isr_controller: directed stimulus queues expected redirects; a negedge monitor pops and compares each flush.
module tb_isr_controller;
  logic clk = 0, rst = 1;
  logic [3:0] irq_in = '0, irq_en = '0, irq_ack;
  logic gie = 0, pipe_stall = 0, branch_flush = 0, jump_flush = 0, id_valid = 0, id_uret = 0;
  logic [31:0] id_pc = '0, isr_pc_new, sav_pc;
  logic ISR_PC_flush, ISR_pipe_flush, isr_running;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic prev_flush = 0;
  typedef struct {int c; logic [31:0] pc; logic [3:0] ack;} exp_t;
  exp_t q[$];

  isr_controller dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_en(irq_en), .gie(gie),
    .pipe_stall(pipe_stall), .branch_flush(branch_flush), .jump_flush(jump_flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_uret(id_uret),
    .ISR_PC_flush(ISR_PC_flush), .ISR_pipe_flush(ISR_pipe_flush), .isr_pc_new(isr_pc_new),
    .irq_ack(irq_ack), .isr_running(isr_running), .sav_pc(sav_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_flush(input int dc, input logic [31:0] pc, input logic [3:0] ack);
    q.push_back('{cyc + dc, pc, ack});
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_flush"}, {30'd0, ISR_PC_flush, ISR_pipe_flush}, 0);
    chk({name, "_pc_new"}, isr_pc_new, 0);
    chk({name, "_ack"}, {28'd0, irq_ack}, 0);
    chk({name, "_running"}, {31'd0, isr_running}, 0);
    chk({name, "_sav_pc"}, sav_pc, 0);
  endtask

  task automatic do_uret(input logic [31:0] pc);
    id_uret = 1;
    expect_flush(1, pc, 4'b0000);
    step(1);
    chk("exit_running", {31'd0, isr_running}, 1);
    id_uret = 0;
    step(1);
    chk("post_exit_running", {31'd0, isr_running}, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ISR_PC_flush === 1'b1 || ISR_pipe_flush === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_flush cyc=%0d got_pc=%h want=no_flush", cyc, isr_pc_new);
      end else begin
        e = q.pop_front();
        chk("flush_cycle", cyc, e.c);
        chk("flush_pair", {30'd0, ISR_PC_flush, ISR_pipe_flush}, 3);
        chk("pc_new", isr_pc_new, e.pc);
        chk("irq_ack", {28'd0, irq_ack}, {28'd0, e.ack});
      end
      if (prev_flush) begin
        n_cmp++; n_bad++;
        $display("FAIL adjacent_flush cyc=%0d got=back_to_back want=gap", cyc);
      end
    end else if (!rst) chk("ack_idle", {28'd0, irq_ack}, 0);
    prev_flush <= ISR_PC_flush | ISR_pipe_flush;
  end

  initial begin
    step(2);
    rst = 0;
    chk_idle("reset");
    // basic entry on line 2, line dropped during ENTER
    gie = 1; irq_en = 4'b1111; id_pc = 32'h100; id_valid = 1; irq_in = 4'b0100;
    expect_flush(1, 32'h1020, 4'b0100);
    step(1);
    chk("entry_running", {31'd0, isr_running}, 1);
    chk("entry_sav_pc", sav_pc, 32'h100);
    irq_in = 0; id_pc = 32'h104;
    step(2);
    chk("run_running", {31'd0, isr_running}, 1);
    do_uret(32'h100);
    // uret while idle
    id_uret = 1;
    step(3);
    id_uret = 0;
    chk("idle_uret_running", {31'd0, isr_running}, 0);
    // priority and mask
    irq_en = 4'b1000; irq_in = 4'b1010; id_pc = 32'h200;
    expect_flush(1, 32'h1030, 4'b1000);
    step(1);
    irq_in = 0;
    step(1);
    do_uret(32'h200);
    gie = 0; irq_en = 4'b1111; irq_in = 4'b1111;
    step(4);
    chk("gie_off_running", {31'd0, isr_running}, 0);
    irq_in = 0; gie = 1;
    // deferral by stall then branch flush
    irq_in = 4'b0001; pipe_stall = 1; id_pc = 32'h300;
    step(3);
    pipe_stall = 0; branch_flush = 1;
    step(1);
    branch_flush = 0; id_pc = 32'h340;
    expect_flush(1, 32'h1000, 4'b0001);
    step(1);
    chk("defer_sav_pc", sav_pc, 32'h340);
    irq_in = 0; id_pc = 32'h999;
    step(1);
    jump_flush = 1; id_uret = 1;
    step(2);
    chk("uret_jump_deferred", {31'd0, isr_running}, 1);
    jump_flush = 0;
    do_uret(32'h340);
    // held lines: no nesting, re-entry two cycles after uret acceptance
    irq_in = 4'b0011; id_pc = 32'h400;
    expect_flush(1, 32'h1000, 4'b0001);
    step(4);
    id_uret = 1;
    expect_flush(1, 32'h400, 4'b0000);
    step(1);
    id_uret = 0; id_pc = 32'h404;
    expect_flush(2, 32'h1000, 4'b0001);
    step(2);
    chk("reentry_sav_pc", sav_pc, 32'h404);
    irq_in = 0;
    step(1);
    do_uret(32'h404);
    // reset during ENTER
    irq_in = 4'b0010; id_pc = 32'h500;
    expect_flush(1, 32'h1010, 4'b0010);
    step(1);
    irq_in = 0; rst = 1;
    step(1);
    rst = 0;
    chk_idle("rst_enter");
    // reset during RUN
    irq_in = 4'b0100;
    expect_flush(1, 32'h1020, 4'b0100);
    step(1);
    irq_in = 0;
    step(2);
    rst = 1;
    step(1);
    rst = 0;
    chk_idle("rst_run");
    // normal entry after reset
    irq_in = 4'b1000; id_pc = 32'h600;
    expect_flush(1, 32'h1030, 4'b1000);
    step(1);
    chk("post_rst_sav_pc", sav_pc, 32'h600);
    irq_in = 0;
    step(1);
    do_uret(32'h600);
    step(2);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
